// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the RV32 pipeline memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ADDR, RESP)
//   arb_owner_t : which pipeline side owns the bus transaction
//   mem_req_t   : request payload carried on the unified memory bus
package pipeline_pkg;

  // Data/address width used by the bus payload struct.
  localparam int unsigned MEM_XLEN = 32;
  localparam int unsigned MEM_BE_W = MEM_XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                we;
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_XLEN-1:0] wdata;
    logic [MEM_BE_W-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered memory port between instruction
// fetch (IF) and the MEM-stage data access (DM). Data has fixed priority over
// fetch; one transaction is in flight at a time.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr/if_flush            fetch request side
//   if_valid/if_rdata/if_stall         fetch response and stall
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be data request side
//   dm_valid/dm_rdata/dm_stall         data response and stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered bus request
//   mem_gnt/mem_rvalid/mem_rdata       bus grant and response
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = MEM_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [XLEN-1:0]   dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  input  logic [XLEN/8-1:0] dm_be,
  output logic              dm_valid,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  arb_state_t st_q, st_d;
  arb_owner_t owner_q, owner_d;
  logic       drop_q, drop_d;
  logic       mem_req_q, mem_req_d;
  mem_req_t   req_q, req_d;

  mem_req_t   if_pl;
  mem_req_t   dm_pl;
  logic       if_ok;
  logic       rsp_done;
  logic       flush_hit;

  // A fetch may only be captured in a cycle without a redirect.
  assign if_ok     = if_req && !if_flush;
  assign rsp_done  = (st_q == RESP) && mem_rvalid;
  assign flush_hit = if_flush && (owner_q == OWN_IF);

  // Build the candidate payloads for each side; fetches are full-word reads.
  always_comb begin
    if_pl       = {$bits(mem_req_t){1'b0}};
    if_pl.we    = 1'b0;
    if_pl.addr  = if_addr;
    if_pl.wdata = {XLEN{1'b0}};
    if_pl.be    = {(XLEN/8){1'b1}};
    dm_pl       = {$bits(mem_req_t){1'b0}};
    dm_pl.we    = dm_we;
    dm_pl.addr  = dm_addr;
    dm_pl.wdata = dm_wdata;
    dm_pl.be    = dm_be;
  end

  // Next-state logic: arbitration, payload capture and flush tracking.
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    req_d   = req_q;
    case (st_q)
      IDLE: begin
        if (dm_req) begin
          st_d    = ADDR;
          owner_d = OWN_DM;
          req_d   = dm_pl;
        end else if (if_ok) begin
          st_d    = ADDR;
          owner_d = OWN_IF;
          req_d   = if_pl;
        end else begin
          st_d    = IDLE;
        end
      end
      ADDR: begin
        if (mem_gnt) begin
          st_d = RESP;
        end else begin
          st_d = ADDR;
        end
        if (flush_hit) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          // The completing side still shows its old request, so only the
          // other side is eligible here.
          drop_d = 1'b0;
          if ((owner_q == OWN_IF) && dm_req) begin
            st_d    = ADDR;
            owner_d = OWN_DM;
            req_d   = dm_pl;
          end else if ((owner_q == OWN_DM) && if_ok) begin
            st_d    = ADDR;
            owner_d = OWN_IF;
            req_d   = if_pl;
          end else begin
            st_d    = IDLE;
          end
        end else if (flush_hit) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
    mem_req_d = (st_d == ADDR);
  end

  // State, owner, drop flag and registered bus request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      owner_q   <= OWN_IF;
      drop_q    <= 1'b0;
      mem_req_q <= 1'b0;
      req_q     <= {$bits(mem_req_t){1'b0}};
    end else begin
      st_q      <= st_d;
      owner_q   <= owner_d;
      drop_q    <= drop_d;
      mem_req_q <= mem_req_d;
      req_q     <= req_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;

  // A flush landing on the response cycle must also hide that response.
  assign if_valid  = rsp_done && (owner_q == OWN_IF) && !drop_q && !if_flush;
  assign dm_valid  = rsp_done && (owner_q == OWN_DM);
  assign if_rdata  = mem_rdata[31:0];
  assign dm_rdata  = mem_rdata;
  assign if_stall  = if_req && !if_valid;
  assign dm_stall  = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter.
// A bus slave model answers requests with configurable or random latency;
// expected responses are queued per side when a request is issued and a
// monitor pops and compares them whenever the arbiter presents a response.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] data; } dm_exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] if_exp_q[$];
  dm_exp_t     dm_exp_q[$];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  bit          if_done = 1'b0, dm_done = 1'b0;
  bit          stim_on = 1'b0;
  bit          slave_rand = 1'b0;
  int          gnt_cfg = 0, rv_cfg = 0;
  int          if_age = 0, dm_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  // Bus slave: decides grant/response at each falling edge.
  logic        s_trk, s_pend, s_we;
  int          s_gcnt, s_rcnt;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    s_trk = 1'b0; s_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_trk = 1'b0; s_pend = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom();
        if (s_pend) begin
          if (s_rcnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = s_rdata; s_pend = 1'b0;
          end else s_rcnt--;
        end
        mem_gnt = 1'b0;
        if (s_trk) begin
          chk("req_held", mem_req, 1'b1);
          chk("payload_held", (mem_we === s_we) && (mem_addr === s_addr) &&
              (mem_wdata === s_wdata) && (mem_be === s_be), 1'b1);
        end
        if (mem_req) begin
          if (!s_trk) begin
            s_trk = 1'b1;
            s_gcnt = slave_rand ? int'($urandom_range(0, 3)) : gnt_cfg;
            s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be;
          end
          if (s_gcnt == 0) begin
            mem_gnt = 1'b1;
            s_trk = 1'b0;
            if (mem_we) begin
              slv_mem[mem_addr] = merge(slv_rd(mem_addr), mem_wdata, mem_be);
              s_rdata = $urandom();
            end else s_rdata = slv_rd(mem_addr);
            s_pend = 1'b1;
            s_rcnt = slave_rand ? int'($urandom_range(0, 2)) : rv_cfg;
          end else s_gcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (if_valid) begin
        if_done = 1'b1;
        if (if_exp_q.size() == 0) chk("if_unexpected", if_valid, 1'b0);
        else chk("if_rdata", if_rdata, if_exp_q.pop_front());
        chk("if_stall_on_valid", if_stall, 1'b0);
      end else begin
        chk("if_stall", if_stall, if_req);
      end
      if (dm_valid) begin
        dm_done = 1'b1;
        if (dm_exp_q.size() == 0) chk("dm_unexpected", dm_valid, 1'b0);
        else begin
          dm_exp_t e;
          e = dm_exp_q.pop_front();
          if (!e.we) chk("dm_rdata", dm_rdata, e.data);
        end
        chk("dm_stall_on_valid", dm_stall, 1'b0);
      end else begin
        chk("dm_stall", dm_stall, dm_req);
      end
    end
  end

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] a, input logic [31:0] exp);
    if_req = 1'b1; if_addr = a; if_exp_q.push_back(exp);
  endtask

  task automatic issue_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    dm_exp_t e;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
    e.we = we;
    e.data = ref_rd(a);
    if (we) ref_mem[a] = merge(ref_rd(a), wd, be);
    dm_exp_q.push_back(e);
  endtask

  task automatic drive_if();
    logic [31:0] a;
    if_flush = 1'b0;
    if (if_req && if_done) begin if_req = 1'b0; if_age = 0; end
    if (!if_req) begin
      if (stim_on && $urandom_range(0, 2) == 0) begin
        a = 32'h1000 + 4 * $urandom_range(0, 255);
        issue_if(a, init_word(a));
      end
    end else begin
      if_age++;
      if (if_age == 41) chk("if_starve", if_age, 40);
      if ($urandom_range(0, 15) == 0) begin
        if_flush = 1'b1;
        void'(if_exp_q.pop_back());
        if_age = 0;
        if (stim_on) begin
          a = 32'h1000 + 4 * $urandom_range(0, 255);
          issue_if(a, init_word(a));
        end else if_req = 1'b0;
      end
    end
    if_done = 1'b0;
  endtask

  task automatic drive_dm();
    if (dm_req && dm_done) begin dm_req = 1'b0; dm_age = 0; end
    if (!dm_req) begin
      if (stim_on && $urandom_range(0, 2) == 0)
        issue_dm(1'($urandom_range(0, 1)), 32'h2000 + 4 * $urandom_range(0, 7),
                 $urandom(), 4'($urandom_range(1, 15)));
    end else begin
      dm_age++;
      if (dm_age == 41) chk("dm_starve", dm_age, 40);
    end
    dm_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_payload", {mem_we, mem_addr, mem_wdata, mem_be} == 69'h0, 1'b1);
    chk("rst_valids", {if_valid, dm_valid}, 2'b00);
    rst_n = 1'b1;

    // Fetch only, 3-cycle latency.
    slv_mem[32'h100] = 32'h00500093;
    nc(); issue_if(32'h100, 32'h00500093);
    #2; chk("t1_req_t", mem_req, 1'b0); chk("t1_stall_t", if_stall, 1'b1);
    nc(); #2; chk("t1_req_t1", mem_req, 1'b1); chk("t1_addr", mem_addr, 32'h100);
    chk("t1_we", mem_we, 1'b0); chk("t1_be", mem_be, 4'hF); chk("t1_stall_t1", if_stall, 1'b1);
    nc(); #2; chk("t1_valid", if_valid, 1'b1); chk("t1_rdata", if_rdata, 32'h00500093);
    nc(); if_req = 1'b0;

    // Simultaneous fetch and store: store first, fetch follows.
    nc(); issue_if(32'h104, init_word(32'h104));
    issue_dm(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
    nc(); #2; chk("t2_st_req", mem_req, 1'b1); chk("t2_st_we", mem_we, 1'b1);
    chk("t2_st_addr", mem_addr, 32'h2000); chk("t2_st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t2_st_be", mem_be, 4'hF);
    nc(); #2; chk("t2_st_valid", dm_valid, 1'b1); chk("t2_req_gap", mem_req, 1'b0);
    nc(); dm_req = 1'b0; #2; chk("t2_if_req", mem_req, 1'b1);
    chk("t2_if_addr", mem_addr, 32'h104); chk("t2_if_we", mem_we, 1'b0);
    nc(); #2; chk("t2_if_valid", if_valid, 1'b1);
    nc(); if_req = 1'b0;

    // Grant withheld for 3 cycles.
    gnt_cfg = 3;
    nc(); issue_if(32'h108, init_word(32'h108));
    for (int i = 1; i <= 4; i++) begin
      nc(); #2; chk("t3_req_held", mem_req, 1'b1); chk("t3_addr_held", mem_addr, 32'h108);
      chk("t3_gnt", mem_gnt, (i == 4) ? 1'b1 : 1'b0);
    end
    nc(); #2; chk("t3_valid", if_valid, 1'b1);
    nc(); if_req = 1'b0; gnt_cfg = 0;

    // Flush while the fetch is in RESP: response dropped, new fetch issued.
    rv_cfg = 2;
    nc(); issue_if(32'h10C, init_word(32'h10C));
    nc();
    nc(); if_flush = 1'b1; void'(if_exp_q.pop_back());
    issue_if(32'h200, init_word(32'h200));
    #2; chk("t4_no_valid_flush", if_valid, 1'b0);
    nc(); if_flush = 1'b0; rv_cfg = 0;
    nc(); #2; chk("t4_dropped", if_valid, 1'b0);
    nc();
    nc(); #2; chk("t4_new_req", mem_req, 1'b1); chk("t4_new_addr", mem_addr, 32'h200);
    nc(); #2; chk("t4_new_valid", if_valid, 1'b1);
    nc(); if_req = 1'b0;

    // Load with fetch pending: load returns, fetch granted next.
    slv_mem[32'h3000] = 32'h12345678; ref_mem[32'h3000] = 32'h12345678;
    nc(); issue_dm(1'b0, 32'h3000, 32'h0, 4'hF); issue_if(32'h110, init_word(32'h110));
    nc(); #2; chk("t5_ld_addr", mem_addr, 32'h3000); chk("t5_ld_we", mem_we, 1'b0);
    nc(); #2; chk("t5_ld_valid", dm_valid, 1'b1); chk("t5_ld_data", dm_rdata, 32'h12345678);
    chk("t5_if_wait", if_valid, 1'b0);
    nc(); dm_req = 1'b0; #2; chk("t5_if_req", mem_req, 1'b1); chk("t5_if_addr", mem_addr, 32'h110);
    nc(); #2; chk("t5_if_valid", if_valid, 1'b1);
    nc(); if_req = 1'b0;

    // Reset during RESP, then a fresh fetch.
    rv_cfg = 3;
    nc(); issue_if(32'h114, init_word(32'h114));
    nc();
    nc(); rst_n = 1'b0; #1;
    chk("t6_rst_req", mem_req, 1'b0); chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_be", mem_be, 4'h0); chk("t6_rst_valid", {if_valid, dm_valid}, 2'b00);
    if_exp_q.delete(); if_req = 1'b0;
    nc();
    nc(); rst_n = 1'b1; rv_cfg = 0;
    nc(); issue_if(32'h118, init_word(32'h118));
    nc(); #2; chk("t6_req_after", mem_req, 1'b1);
    nc(); #2; chk("t6_valid_after", if_valid, 1'b1);
    nc(); if_req = 1'b0;

    // Randomized traffic on both sides.
    nc();
    if_done = 1'b0; dm_done = 1'b0; if_age = 0; dm_age = 0;
    slave_rand = 1'b1; stim_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      nc(); drive_if(); drive_dm();
    end
    stim_on = 1'b0;
    for (int c = 0; c < 300 && (if_req || dm_req); c++) begin
      nc(); drive_if(); drive_dm();
    end
    chk("drain_done", {if_req, dm_req}, 2'b00);
    repeat (12) nc();
    chk("if_q_empty", if_exp_q.size(), 0);
    chk("dm_q_empty", dm_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
